// File: rtl/renode_pkg.sv
// Shared types for the Renode co-simulation bus stages: access sizes, AXI responses
// and the AXI4-Lite manager state encoding, plus small lane/size helpers.
package renode_pkg;

  typedef enum logic [1:0] {
    Byte       = 2'd0,
    Word       = 2'd1,
    DoubleWord = 2'd2,
    QuadWord   = 2'd3
  } valid_bits_e;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_e;

  typedef enum logic [2:0] {
    IDLE,
    WADDR_DATA,
    WRESP,
    RADDR,
    RDATA,
    RESPOND,
    DRAIN
  } axil_manager_state_e;

  function automatic int unsigned size_bytes(input valid_bits_e s);
    return 32'd1 << s;
  endfunction

  // Byte-lane strobe pattern for an access starting at lane 0.
  function automatic logic [7:0] lane_mask(input valid_bits_e s);
    case (s)
      Byte:       return 8'h01;
      Word:       return 8'h03;
      DoubleWord: return 8'h0F;
      default:    return 8'hFF;
    endcase
  endfunction

  function automatic logic [63:0] size_mask(input valid_bits_e s);
    case (s)
      Byte:       return 64'h0000_0000_0000_00FF;
      Word:       return 64'h0000_0000_0000_FFFF;
      DoubleWord: return 64'h0000_0000_FFFF_FFFF;
      default:    return 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

endpackage

// File: rtl/renode_timeout_counter.sv
// Per-access watchdog: start on request accept, clear when the access leaves the AXI
// phases. expired rises so that the forced response lands TimeoutCycles after accept.
module renode_timeout_counter #(
  parameter int TimeoutCycles = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic clear,
  output logic expired
);

  localparam int CntW = (TimeoutCycles < 2) ? 1 : $clog2(TimeoutCycles + 1);
  // One cycle is consumed registering the response, so fire one count early.
  localparam logic [CntW-1:0] Limit = CntW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);

  logic [CntW-1:0] cnt;
  logic            running;

  assign expired = (TimeoutCycles != 0) && running && (cnt >= Limit);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt     <= '0;
      running <= 1'b0;
    end else if (start) begin
      cnt     <= CntW'(1);
      running <= 1'b1;
    end else if (running && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/renode_axi_lite_manager.sv
// Executes one Renode bus access at a time as an AXI4-Lite transaction, with a per-access
// timeout. Define RENODE_AXI_ALIGNMENT_CHECK_EN to reject accesses not aligned to their size.
module renode_axi_lite_manager
  import renode_pkg::*;
#(
  parameter int AddressWidth  = 20,
  parameter int DataWidth     = 32,
  parameter int TimeoutCycles = 100
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [1:0]               req_size,
  input  logic [AddressWidth-1:0]  req_address,
  input  logic [63:0]              req_wdata,
  output logic                     rsp_valid,
  output logic                     rsp_error,
  output logic [63:0]              rsp_rdata,
  output logic [AddressWidth-1:0]  m_axi_awaddr,
  output logic                     m_axi_awvalid,
  input  logic                     m_axi_awready,
  output logic [DataWidth-1:0]     m_axi_wdata,
  output logic [DataWidth/8-1:0]   m_axi_wstrb,
  output logic                     m_axi_wvalid,
  input  logic                     m_axi_wready,
  input  logic [1:0]               m_axi_bresp,
  input  logic                     m_axi_bvalid,
  output logic                     m_axi_bready,
  output logic [AddressWidth-1:0]  m_axi_araddr,
  output logic                     m_axi_arvalid,
  input  logic                     m_axi_arready,
  input  logic [DataWidth-1:0]     m_axi_rdata,
  input  logic [1:0]               m_axi_rresp,
  input  logic                     m_axi_rvalid,
  output logic                     m_axi_rready
);

  localparam int Lanes = DataWidth / 8;
  localparam int OffW  = $clog2(Lanes);

  axil_manager_state_e state, state_n;

  logic                    write_q;
  valid_bits_e             size_q;
  logic [AddressWidth-1:0] addr_q;
  logic [DataWidth-1:0]    wdata_q;
  logic                    aw_done, w_done, ar_done;
  logic                    rsp_fire, rsp_err_n;
  logic [63:0]             rsp_data_n;
  logic                    accept, illegal, expired;
  logic                    timer_start, timer_clear;
  logic [OffW-1:0]         req_off, off_q;
  logic [63:0]             rd_lane;

  assign req_off = req_address[OffW-1:0];
  assign off_q   = addr_q[OffW-1:0];
  assign accept  = req_valid && req_ready;

  // Anything that would need a second beat is rejected before touching the bus.
  always_comb begin
    illegal = (size_bytes(valid_bits_e'(req_size)) + 32'(req_off)) > 32'(Lanes);
`ifdef RENODE_AXI_ALIGNMENT_CHECK_EN
    if ((32'(req_address[2:0]) & (size_bytes(valid_bits_e'(req_size)) - 32'd1)) != 32'd0)
      illegal = 1'b1;
`endif
  end

  assign m_axi_awaddr = addr_q;
  assign m_axi_araddr = addr_q;
  assign m_axi_wdata  = wdata_q << {off_q, 3'b000};
  assign m_axi_wstrb  = Lanes'(lane_mask(size_q)) << off_q;
  assign rd_lane      = (64'(m_axi_rdata) >> {off_q, 3'b000}) & size_mask(size_q);

  assign timer_start = accept && !illegal;
  assign timer_clear = (state_n == IDLE) || (state_n == RESPOND) || (state_n == DRAIN);

  renode_timeout_counter #(.TimeoutCycles(TimeoutCycles)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .start   (timer_start),
    .clear   (timer_clear),
    .expired (expired)
  );

  always_comb begin
    state_n       = state;
    req_ready     = 1'b0;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_bready  = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    rsp_fire      = 1'b0;
    rsp_err_n     = 1'b0;
    rsp_data_n    = '0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (illegal) begin
            state_n   = RESPOND;
            rsp_fire  = 1'b1;
            rsp_err_n = 1'b1;
          end else begin
            state_n = req_write ? WADDR_DATA : RADDR;
          end
        end
      end
      WADDR_DATA: begin
        m_axi_awvalid = !aw_done;
        m_axi_wvalid  = !w_done;
        if (expired) begin
          state_n   = DRAIN;
          rsp_fire  = 1'b1;
          rsp_err_n = 1'b1;
        end else if ((aw_done || m_axi_awready) && (w_done || m_axi_wready)) begin
          state_n = WRESP;
        end
      end
      WRESP: begin
        m_axi_bready = 1'b1;
        // A response arriving on the expiry cycle still wins over the timeout.
        if (m_axi_bvalid) begin
          state_n   = RESPOND;
          rsp_fire  = 1'b1;
          rsp_err_n = axi_resp_e'(m_axi_bresp) != OKAY;
        end else if (expired) begin
          state_n   = DRAIN;
          rsp_fire  = 1'b1;
          rsp_err_n = 1'b1;
        end
      end
      RADDR: begin
        m_axi_arvalid = 1'b1;
        if (expired) begin
          state_n   = DRAIN;
          rsp_fire  = 1'b1;
          rsp_err_n = 1'b1;
        end else if (m_axi_arready) begin
          state_n = RDATA;
        end
      end
      RDATA: begin
        m_axi_rready = 1'b1;
        if (m_axi_rvalid) begin
          state_n    = RESPOND;
          rsp_fire   = 1'b1;
          rsp_err_n  = axi_resp_e'(m_axi_rresp) != OKAY;
          rsp_data_n = rsp_err_n ? 64'd0 : rd_lane;
        end else if (expired) begin
          state_n   = DRAIN;
          rsp_fire  = 1'b1;
          rsp_err_n = 1'b1;
        end
      end
      RESPOND: state_n = IDLE;
      DRAIN: begin
        // Valids already raised must complete; the late response is swallowed.
        if (write_q) begin
          m_axi_awvalid = !aw_done;
          m_axi_wvalid  = !w_done;
          m_axi_bready  = aw_done && w_done;
          if (m_axi_bvalid && m_axi_bready) state_n = IDLE;
        end else begin
          m_axi_arvalid = !ar_done;
          m_axi_rready  = ar_done;
          if (m_axi_rvalid && m_axi_rready) state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      write_q   <= 1'b0;
      size_q    <= Byte;
      addr_q    <= '0;
      wdata_q   <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      ar_done   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_error <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state     <= state_n;
      rsp_valid <= rsp_fire;
      rsp_error <= rsp_fire && rsp_err_n;
      rsp_rdata <= rsp_fire ? rsp_data_n : 64'd0;
      if (accept) begin
        write_q <= req_write;
        size_q  <= valid_bits_e'(req_size);
        addr_q  <= req_address;
        wdata_q <= req_wdata[DataWidth-1:0];
        aw_done <= 1'b0;
        w_done  <= 1'b0;
        ar_done <= 1'b0;
      end else begin
        aw_done <= aw_done || (m_axi_awvalid && m_axi_awready);
        w_done  <= w_done  || (m_axi_wvalid  && m_axi_wready);
        ar_done <= ar_done || (m_axi_arvalid && m_axi_arready);
      end
    end
  end

endmodule

// File: tb/tb_renode_axi_lite_manager.sv
// Scoreboard bench for renode_axi_lite_manager: directed accesses against a simple AXI4-Lite
// slave model; a negedge monitor pops expected responses and AXI beats as they appear.
module tb_renode_axi_lite_manager;
  import renode_pkg::*;

  localparam int AW = 20;
  localparam int DW = 32;
  localparam int TO = 100;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [1:0]    req_size = 2'd0;
  logic [AW-1:0] req_address = '0;
  logic [63:0]   req_wdata = '0;
  logic          rsp_valid, rsp_error;
  logic [63:0]   rsp_rdata;
  logic [AW-1:0] awaddr, araddr;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [DW-1:0] wdata, rdata;
  logic [DW/8-1:0] wstrb;
  logic [1:0]    bresp, rresp;

  always #5 clk = ~clk;

  renode_axi_lite_manager #(.AddressWidth(AW), .DataWidth(DW), .TimeoutCycles(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_size(req_size),
    .req_address(req_address), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_error(rsp_error), .rsp_rdata(rsp_rdata),
    .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_araddr(araddr), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic err; logic [63:0] data; int lat; int acc; } rsp_t;
  typedef struct { logic [DW-1:0] data; logic [DW/8-1:0] strb; } w_t;
  rsp_t          rsp_q[$];
  logic [AW-1:0] aw_q[$];
  logic [AW-1:0] ar_q[$];
  w_t            w_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Slave knobs
  int            aw_lag = 0;
  bit            aw_block = 0, r_never = 0;
  logic [1:0]    bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  logic [DW-1:0] rdata_cfg = '0;

  // Slave model: handshakes observed mid-cycle, next outputs driven just after the edge.
  bit aw_got = 0, w_got = 0, r_pend = 0;
  bit aw_hs, w_hs, b_hs, ar_hs, r_hs;
  int lagcnt = 0;
  initial begin
    awready = 1'b1; wready = 1'b1; arready = 1'b1;
    bvalid = 1'b0; bresp = 2'b00; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
    forever begin
      @(negedge clk);
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      b_hs  = bvalid && bready;
      ar_hs = arvalid && arready;
      r_hs  = rvalid && rready;
      @(posedge clk); #1;
      if (rst) begin
        aw_got = 0; w_got = 0; r_pend = 0; lagcnt = 0; bvalid = 1'b0; rvalid = 1'b0;
      end else begin
        if (aw_hs) aw_got = 1;
        if (w_hs)  w_got = 1;
        if (ar_hs) r_pend = 1;
        if (b_hs) begin bvalid = 1'b0; aw_got = 0; w_got = 0; lagcnt = 0; end
        if (r_hs) begin rvalid = 1'b0; r_pend = 0; end
        if (w_got && !aw_got) lagcnt++;
        if (aw_got && w_got && !bvalid) begin bvalid = 1'b1; bresp = bresp_cfg; end
        if (r_pend && !rvalid && !r_never) begin rvalid = 1'b1; rdata = rdata_cfg; rresp = rresp_cfg; end
      end
      awready = aw_block ? 1'b0 : (aw_lag == 0) ? 1'b1 : (w_got && lagcnt >= aw_lag);
    end
  end

  // Monitor / scoreboard
  rsp_t e;
  w_t   we;
  always @(negedge clk) begin
    if (rsp_valid) begin
      if (rsp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_rsp actual err=%0d data=0x%0h required=none", rsp_error, rsp_rdata);
      end else begin
        e = rsp_q.pop_front();
        chk("rsp_error", 64'(rsp_error), 64'(e.err));
        chk("rsp_rdata", rsp_rdata, e.data);
        if (e.lat > 0) chk("rsp_latency", 64'(cyc + 1 - e.acc), 64'(e.lat));
      end
    end
    if (awvalid && awready) begin
      if (aw_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_aw actual addr=0x%0h required=none", awaddr);
      end else chk("awaddr", 64'(awaddr), 64'(aw_q.pop_front()));
    end
    if (wvalid && wready) begin
      if (w_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_w actual data=0x%0h required=none", wdata);
      end else begin
        we = w_q.pop_front();
        chk("wdata", 64'(wdata), 64'(we.data));
        chk("wstrb", 64'(wstrb), 64'(we.strb));
      end
    end
    if (arvalid && arready) begin
      if (ar_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_ar actual addr=0x%0h required=none", araddr);
      end else chk("araddr", 64'(araddr), 64'(ar_q.pop_front()));
    end
  end

  task automatic issue(input bit wr, input logic [1:0] sz, input logic [AW-1:0] a,
                       input logic [63:0] wd, input bit eerr, input logic [63:0] edata,
                       input int elat);
    int n = 0;
    while (!req_ready && n < 500) begin @(posedge clk); #1; n++; end
    if (!req_ready) begin
      chk("req_ready_wait", 64'(req_ready), 64'd1);
      return;
    end
    req_valid = 1'b1; req_write = wr; req_size = sz; req_address = a; req_wdata = wd;
    @(posedge clk); #1;
    rsp_q.push_back('{eerr, edata, elat, cyc});
    req_valid = 1'b0; req_wdata = '0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (rsp_q.size() != 0 && n < 300) begin @(posedge clk); #1; n++; end
    if (rsp_q.size() != 0) begin
      chk(name, 64'(rsp_q.size()), 64'd0);
      rsp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_rsp", {61'd0, rsp_valid, rsp_error, 1'b0}, 64'd0);
    chk("rst_rsp_rdata", rsp_rdata, 64'd0);
    chk("rst_axi_valids", {59'd0, awvalid, wvalid, bready, arvalid, rready}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Write DoubleWord 0xDEADBEEF @0x100
    aw_q.push_back(20'h100); w_q.push_back('{32'hDEADBEEF, 4'hF});
    issue(1, 2'd2, 20'h100, 64'hDEADBEEF, 0, 64'd0, 3);
    wait_done("wr_dw_done");

    // Read Byte @0x103
    rdata_cfg = 32'hAABBCCDD;
    ar_q.push_back(20'h103);
    issue(0, 2'd0, 20'h103, 64'd0, 0, 64'hAA, 3);
    wait_done("rd_byte_done");

    // Write Word @0x202 with AWREADY lagging WREADY by 5 cycles
    aw_lag = 5;
    aw_q.push_back(20'h202); w_q.push_back('{32'h12340000, 4'b1100});
    issue(1, 2'd1, 20'h202, 64'h1234, 0, 64'd0, 0);
    wait_done("wr_word_lag_done");
    aw_lag = 0;

    // Illegal sizes: QuadWord, and lane-crossing Word @0x3
    issue(0, 2'd3, 20'h000, 64'd0, 1, 64'd0, 0);
    wait_done("rd_qw_done");
    issue(0, 2'd1, 20'h003, 64'd0, 1, 64'd0, 0);
    wait_done("rd_cross_done");

`ifdef RENODE_AXI_ALIGNMENT_CHECK_EN
    issue(0, 2'd1, 20'h001, 64'd0, 1, 64'd0, 0);
    wait_done("rd_unaligned_done");
    issue(1, 2'd1, 20'h001, 64'hBEEF, 1, 64'd0, 0);
    wait_done("wr_unaligned_done");
`else
    rdata_cfg = 32'h11223344;
    ar_q.push_back(20'h001);
    issue(0, 2'd1, 20'h001, 64'd0, 0, 64'h2233, 3);
    wait_done("rd_unaligned_done");
    aw_q.push_back(20'h001); w_q.push_back('{32'h00BEEF00, 4'b0110});
    issue(1, 2'd1, 20'h001, 64'hBEEF, 0, 64'd0, 3);
    wait_done("wr_unaligned_done");
`endif

    // Error responses
    rresp_cfg = 2'b10; rdata_cfg = 32'h55555555;
    ar_q.push_back(20'h008);
    issue(0, 2'd2, 20'h008, 64'd0, 1, 64'd0, 3);
    wait_done("rd_slverr_done");
    rresp_cfg = 2'b00;
    bresp_cfg = 2'b11;
    aw_q.push_back(20'h007); w_q.push_back('{32'h5A000000, 4'b1000});
    issue(1, 2'd0, 20'h007, 64'h5A, 1, 64'd0, 3);
    wait_done("wr_decerr_done");
    bresp_cfg = 2'b00;

    // Timeout: slave never answers R
    r_never = 1;
    ar_q.push_back(20'h010);
    issue(0, 2'd2, 20'h010, 64'd0, 1, 64'd0, TO);
    wait_done("timeout_done");
    repeat (3) begin
      chk("req_ready_draining", 64'(req_ready), 64'd0);
      @(posedge clk); #1;
    end
    rdata_cfg = 32'h99999999;
    r_never = 0;
    begin
      int n = 0;
      while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
      chk("req_ready_after_drain", 64'(req_ready), 64'd1);
    end
    rdata_cfg = 32'hCAFE1234;
    ar_q.push_back(20'h020);
    issue(0, 2'd2, 20'h020, 64'd0, 0, 64'hCAFE1234, 3);
    wait_done("rd_after_drain_done");

    // Reset while AWVALID is pending
    aw_block = 1;
    aw_q.push_back(20'h040); w_q.push_back('{32'h11112222, 4'hF});
    issue(1, 2'd2, 20'h040, 64'h11112222, 0, 64'd0, 0);
    begin
      int n = 0;
      while (!awvalid && n < 10) begin @(posedge clk); #1; n++; end
      chk("awvalid_pending", 64'(awvalid), 64'd1);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_req_ready", 64'(req_ready), 64'd1);
    chk("midrst_rsp", {61'd0, rsp_valid, rsp_error, 1'b0}, 64'd0);
    chk("midrst_axi_valids", {59'd0, awvalid, wvalid, bready, arvalid, rready}, 64'd0);
    rst = 1'b0;
    aw_q.delete(); w_q.delete(); rsp_q.delete();
    aw_block = 0;
    repeat (3) @(posedge clk);
    #1;

    // Recovery write Word 0xABCD @0x0
    aw_q.push_back(20'h000); w_q.push_back('{32'h0000ABCD, 4'b0011});
    issue(1, 2'd1, 20'h000, 64'hABCD, 0, 64'd0, 3);
    wait_done("wr_after_rst_done");

    repeat (5) @(posedge clk);
    #1;
    chk("leftover_rsp", 64'(rsp_q.size()), 64'd0);
    chk("leftover_axi", 64'(aw_q.size() + w_q.size() + ar_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
